// File: rtl/midi_note_tracker.sv
// midi_note_tracker: MIDI byte-stream parser keeping a 5-slot table of held notes
module midi_note_tracker #(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic             clk_camera_in,
  input  logic             rst_n_in,
  input  logic [7:0]       midi_byte_in,
  input  logic             midi_valid_in,
  output logic [4:0][15:0] received_note,
  output logic [4:0]       note_on_out,
  output logic             valid_note_out,
  output logic             dropped_out
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
  state_t           state_q, state_d;
  logic [3:0]       type_q, type_d;
  logic             match_q, match_d;
  logic [7:0]       key_q, key_d;
  logic [4:0][15:0] rn_q, rn_d;
  logic [4:0]       on_q, on_d;
  logic             valid_q, valid_d, drop_q, drop_d;
  logic             rt, status, exec, is_on, is_off, is_ano;
  logic [4:0]       hit, free_sel;
  assign rt     = midi_byte_in[7:3] == 5'b11111;
  assign status = midi_byte_in[7];
  assign exec   = midi_valid_in && !status && state_q == WAIT_D2 && match_q;
  assign is_on  = type_q == 4'h9 && midi_byte_in != 8'h00;
  assign is_off = type_q == 4'h8 || (type_q == 4'h9 && midi_byte_in == 8'h00);
  assign is_ano = type_q == 4'hB && key_q == 8'h7B;
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    match_d = match_q;
    key_d   = key_q;
    if (midi_valid_in && !rt) begin
      if (midi_byte_in[7:4] == 4'hF) begin
        state_d = IDLE;
        type_d  = 4'h0;
        match_d = 1'b0;
      end else if (status) begin
        state_d = WAIT_D1;
        type_d  = midi_byte_in[7:4];
        match_d = (OMNI != 0) || midi_byte_in[3:0] == CHANNEL[3:0];
      end else if (state_q == WAIT_D1) begin
        key_d   = midi_byte_in;
        state_d = (type_q == 4'hC || type_q == 4'hD) ? WAIT_D1 : WAIT_D2;
      end else if (state_q == WAIT_D2) begin
        state_d = WAIT_D1;
      end
    end
  end
  // Ascending scan so the last free slot seen, i.e. the highest index, wins
  always_comb begin
    free_sel = '0;
    for (int i = 0; i < 5; i++) begin
      hit[i] = on_q[i] && rn_q[i][15:8] == key_q;
      if (!on_q[i]) begin
        free_sel    = '0;
        free_sel[i] = 1'b1;
      end
    end
  end
  always_comb begin
    rn_d    = rn_q;
    on_d    = on_q;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    if (exec && is_on) begin
      if (|hit) begin
        for (int i = 0; i < 5; i++)
          if (hit[i]) rn_d[i][7:0] = midi_byte_in;
        valid_d = 1'b1;
      end else if (|free_sel) begin
        for (int i = 0; i < 5; i++)
          if (free_sel[i]) begin
            rn_d[i] = {key_q, midi_byte_in};
            on_d[i] = 1'b1;
          end
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (exec && is_off) begin
      for (int i = 0; i < 5; i++)
        if (hit[i]) begin
          rn_d[i] = 16'h0000;
          on_d[i] = 1'b0;
        end
      valid_d = |hit;
    end else if (exec && is_ano) begin
      rn_d    = '0;
      on_d    = '0;
      valid_d = |on_q;
    end
  end
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      type_q  <= 4'h0;
      match_q <= 1'b0;
      key_q   <= 8'h00;
      rn_q    <= '0;
      on_q    <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      match_q <= match_d;
      key_q   <= key_d;
      rn_q    <= rn_d;
      on_q    <= on_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end
  assign received_note  = rn_q;
  assign note_on_out    = on_q;
  assign valid_note_out = valid_q;
  assign dropped_out    = drop_q;
endmodule

// File: tb/tb_midi_note_tracker.sv
// tb_midi_note_tracker: directed byte vectors with per-byte expected table state
module tb_midi_note_tracker;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       midi_byte = 8'h00;
  logic             midi_valid = 1'b0;
  logic [4:0][15:0] received_note;
  logic [4:0]       note_on;
  logic             valid_note, dropped;
  int               n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0]  b;
    logic [4:0]  on;
    logic        v;
    logic        d;
    int          slot;
    logic [15:0] val;
  } vec_t;
  vec_t vq[$];
  midi_note_tracker #(.CHANNEL(0), .OMNI(0)) dut (
    .clk_camera_in(clk),
    .rst_n_in(rst_n),
    .midi_byte_in(midi_byte),
    .midi_valid_in(midi_valid),
    .received_note(received_note),
    .note_on_out(note_on),
    .valid_note_out(valid_note),
    .dropped_out(dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] b, input logic [4:0] on, input logic v, input logic d,
                     input int s, input logic [15:0] val);
    vq.push_back('{b, on, v, d, s, val});
  endtask
  task automatic send(input logic [7:0] b);
    midi_byte  = b;
    midi_valid = 1'b1;
    @(negedge clk);
    midi_valid = 1'b0;
  endtask
  task automatic chk_idle(input string name);
    chk({name, ".on"}, 32'(note_on), 32'h0);
    chk({name, ".valid"}, 32'(valid_note), 32'h0);
    chk({name, ".drop"}, 32'(dropped), 32'h0);
    chk({name, ".table"}, 32'(|received_note), 32'h0);
  endtask
  initial begin
    add(8'h90, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h3C, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h64, 5'b10000, 1, 0, 4, 16'h3C64);
    add(8'h40, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h50, 5'b11000, 1, 0, 3, 16'h4050);
    add(8'h3C, 5'b11000, 0, 0, 4, 16'h3C64);
    add(8'h00, 5'b01000, 1, 0, 4, 16'h0000);
    add(8'hB0, 5'b01000, 0, 0, 3, 16'h4050);
    add(8'h7B, 5'b01000, 0, 0, 3, 16'h4050);
    add(8'h00, 5'b00000, 1, 0, 3, 16'h0000);
    add(8'h90, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h3C, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h64, 5'b10000, 1, 0, 4, 16'h3C64);
    add(8'h3D, 5'b10000, 0, 0, 3, 16'h0000);
    add(8'h64, 5'b11000, 1, 0, 3, 16'h3D64);
    add(8'h3E, 5'b11000, 0, 0, 2, 16'h0000);
    add(8'h64, 5'b11100, 1, 0, 2, 16'h3E64);
    add(8'h3F, 5'b11100, 0, 0, 1, 16'h0000);
    add(8'h64, 5'b11110, 1, 0, 1, 16'h3F64);
    add(8'h40, 5'b11110, 0, 0, 0, 16'h0000);
    add(8'h64, 5'b11111, 1, 0, 0, 16'h4064);
    add(8'h41, 5'b11111, 0, 0, 0, 16'h4064);
    add(8'h64, 5'b11111, 0, 1, 0, 16'h4064);
    add(8'h80, 5'b11111, 0, 0, 4, 16'h3C64);
    add(8'h3C, 5'b11111, 0, 0, 4, 16'h3C64);
    add(8'h40, 5'b01111, 1, 0, 4, 16'h0000);
    add(8'h90, 5'b01111, 0, 0, 4, 16'h0000);
    add(8'h41, 5'b01111, 0, 0, 4, 16'h0000);
    add(8'h64, 5'b11111, 1, 0, 4, 16'h4164);
    add(8'h3D, 5'b11111, 0, 0, 3, 16'h3D64);
    add(8'h7F, 5'b11111, 1, 0, 3, 16'h3D7F);
    add(8'hB0, 5'b11111, 0, 0, 0, 16'h4064);
    add(8'h7B, 5'b11111, 0, 0, 0, 16'h4064);
    add(8'h00, 5'b00000, 1, 0, 0, 16'h0000);
    add(8'h7B, 5'b00000, 0, 0, 0, 16'h0000);
    add(8'h00, 5'b00000, 0, 0, 0, 16'h0000);
    add(8'h91, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h3C, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h64, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h90, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'hF8, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h3C, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'hFE, 5'b00000, 0, 0, 4, 16'h0000);
    add(8'h64, 5'b10000, 1, 0, 4, 16'h3C64);
    add(8'h80, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h22, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h40, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'hC0, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h05, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h06, 5'b10000, 0, 0, 4, 16'h3C64);
    add(8'h90, 5'b10000, 0, 0, 3, 16'h0000);
    add(8'h00, 5'b10000, 0, 0, 3, 16'h0000);
    add(8'h10, 5'b11000, 1, 0, 3, 16'h0010);
    add(8'h80, 5'b11000, 0, 0, 3, 16'h0010);
    add(8'h00, 5'b11000, 0, 0, 3, 16'h0010);
    add(8'h00, 5'b10000, 1, 0, 3, 16'h0000);
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vq[k]) begin
      send(vq[k].b);
      chk($sformatf("v%0d.on", k), 32'(note_on), 32'(vq[k].on));
      chk($sformatf("v%0d.valid", k), 32'(valid_note), 32'(vq[k].v));
      chk($sformatf("v%0d.drop", k), 32'(dropped), 32'(vq[k].d));
      chk($sformatf("v%0d.slot%0d", k, vq[k].slot), 32'(received_note[vq[k].slot]), 32'(vq[k].val));
    end
    send(8'h90);
    send(8'h3C);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    @(negedge clk);
    chk_idle("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h64);
    chk_idle("post_rst_data");
    send(8'h3C);
    send(8'h64);
    chk_idle("post_rst_pair");
    send(8'h90);
    send(8'h3C);
    send(8'hF0);
    send(8'h3C);
    send(8'h64);
    chk_idle("sysex_abort");
    send(8'h90);
    send(8'h3C);
    send(8'h64);
    chk("recover.on", 32'(note_on), 32'h10);
    chk("recover.slot4", 32'(received_note[4]), 32'h3C64);
    chk("recover.valid", 32'(valid_note), 32'h1);
    @(negedge clk);
    chk("recover.pulse_len", 32'(valid_note), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
